// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch constants, FSM state encoding and the {instr,pc} packet type
package fetch_unit_pkg;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [6:0]  OP_LUI    = 7'b0110111;
   localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_REG    = 7'b0110011;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} fetch_state_t;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_pkt_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode-side signals of the fetch stage
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        fetch_fault;
   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc, fetch_fault,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );
   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc, fetch_fault,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {instr,pc} holding register used while decode stalls
module fetch_skid_buffer
   import fetch_unit_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_load,
   input  logic       i_unload,
   input  logic       i_clear,
   input  fetch_pkt_t i_pkt,
   output logic       o_full,
   output fetch_pkt_t o_pkt
);
   logic       r_full;
   fetch_pkt_t r_pkt;
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_full <= 1'b0;
         r_pkt  <= '0;
      end else if (i_load) begin
         r_full <= 1'b1;
         r_pkt  <= i_pkt;
      end else if (i_unload) begin
         r_full <= 1'b0;
      end
   end
   assign o_full = r_full;
   assign o_pkt  = r_pkt;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues req/gnt/rvalid fetches and hands {instr,pc} to decode
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   fetch_state_t r_state, w_state_n;
   logic [31:0]  r_pc, w_pc_n, r_pc_infl, w_pc_infl_n;
   logic         r_discard, w_discard_n, r_fault, w_fault_n, r_id_valid, w_id_valid_n;
   fetch_pkt_t   r_id, w_id_n, w_rsp_pkt, w_skid_pkt;
   logic         w_skid_full, w_load, w_unload, w_clear, w_outstanding, w_slot_free;

   assign w_rsp_pkt   = '{instr: bus.imem_rdata, pc: r_pc_infl};
   assign w_slot_free = !r_id_valid || bus.id_ready;
   // A granted response still on its way must be swallowed after a redirect
   assign w_outstanding = (r_state == WAIT && !bus.imem_rvalid) ||
                          (r_state == REQ && bus.imem_gnt) ||
                          (r_state == FAULT && r_discard && !bus.imem_rvalid);

   fetch_skid_buffer u_skid (
      .clk(clk), .reset(reset), .i_load(w_load), .i_unload(w_unload), .i_clear(w_clear),
      .i_pkt(w_rsp_pkt), .o_full(w_skid_full), .o_pkt(w_skid_pkt)
   );

   always_comb begin
      w_state_n    = r_state;
      w_pc_n       = r_pc;
      w_pc_infl_n  = r_pc_infl;
      w_discard_n  = r_discard;
      w_fault_n    = r_fault;
      w_id_valid_n = r_id_valid && !bus.id_ready;
      w_id_n       = r_id;
      w_load       = 1'b0;
      w_unload     = 1'b0;
      w_clear      = 1'b0;
      case (r_state)
         IDLE: w_state_n = REQ;
         REQ: if (bus.imem_gnt) begin
            w_state_n   = WAIT;
            w_pc_infl_n = r_pc;
         end
         WAIT: if (bus.imem_rvalid) begin
            w_state_n = REQ;
            if (r_discard) begin
               w_discard_n = 1'b0;
            end else begin
               w_pc_n = r_pc + 32'd4;
               if (w_slot_free) begin
                  w_id_valid_n = 1'b1;
                  w_id_n       = w_rsp_pkt;
               end else begin
                  w_load    = 1'b1;
                  w_state_n = HOLD;
               end
            end
         end
         HOLD: if (bus.id_ready && w_skid_full) begin
            w_id_valid_n = 1'b1;
            w_id_n       = w_skid_pkt;
            w_unload     = 1'b1;
            w_state_n    = REQ;
         end
         FAULT: if (bus.imem_rvalid) w_discard_n = 1'b0;
         default: w_state_n = IDLE;
      endcase
      if (bus.redirect_valid) begin
         w_pc_n       = bus.redirect_pc;
         w_id_valid_n = 1'b0;
         w_clear      = 1'b1;
         w_load       = 1'b0;
         w_unload     = 1'b0;
         w_discard_n  = w_outstanding;
         w_fault_n    = |bus.redirect_pc[1:0];
         w_state_n    = w_fault_n ? FAULT : (w_outstanding ? WAIT : IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_pc_infl  <= '0;
         r_discard  <= 1'b0;
         r_fault    <= 1'b0;
         r_id_valid <= 1'b0;
         r_id       <= '{instr: NOP_INSTR, pc: '0};
      end else begin
         r_state    <= w_state_n;
         r_pc       <= w_pc_n;
         r_pc_infl  <= w_pc_infl_n;
         r_discard  <= w_discard_n;
         r_fault    <= w_fault_n;
         r_id_valid <= w_id_valid_n;
         r_id       <= w_id_n;
      end
   end

   assign bus.imem_req    = (r_state == REQ);
   assign bus.imem_addr   = r_pc;
   assign bus.id_valid    = r_id_valid;
   assign bus.id_instr    = r_id_valid ? r_id.instr : NOP_INSTR;
   assign bus.id_pc       = r_id.pc;
   assign bus.fetch_fault = r_fault;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch sequencing, stalls, redirects, faults and PC wrap
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          n_checks = 0;
   int          n_errors = 0;
   int          gnt_wait = 0;
   int          rv_lat = 1;
   int          wcnt = 0;
   int          pend = 0;
   logic [31:0] pend_addr = '0;
   logic [31:0] xfers[$];
   logic        r2_rvalid = 1'b0;
   logic [31:0] r2_rdata = '0;
   logic [31:0] exp_xfer[3] = '{32'h0, 32'h4, 32'h8};

   fetch_unit_if f ();
   fetch_unit_if f2 ();

   fetch_unit u_dut (.clk(clk), .reset(reset), .bus(f.master));
   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (.clk(clk), .reset(reset), .bus(f2.master));

   always #5 clk = ~clk;

   // memory model: gnt after gnt_wait cycles of req, rdata=addr rv_lat cycles after gnt
   assign f.imem_gnt    = f.imem_req && (wcnt >= gnt_wait);
   assign f.imem_rvalid = (pend == 1);
   assign f.imem_rdata  = pend_addr;
   always @(posedge clk) begin
      if (reset) begin
         wcnt <= 0;
         pend <= 0;
      end else begin
         wcnt <= (f.imem_req && !f.imem_gnt) ? wcnt + 1 : 0;
         if (f.imem_req && f.imem_gnt) begin
            pend      <= rv_lat;
            pend_addr <= f.imem_addr;
         end else if (pend > 0) begin
            pend <= pend - 1;
         end
         if (f.id_valid && f.id_ready) xfers.push_back(f.id_pc);
      end
   end

   assign f2.imem_gnt       = f2.imem_req;
   assign f2.imem_rvalid    = r2_rvalid;
   assign f2.imem_rdata     = r2_rdata;
   assign f2.redirect_valid = 1'b0;
   assign f2.redirect_pc    = '0;
   assign f2.id_ready       = 1'b1;
   always @(posedge clk) begin
      r2_rvalid <= !reset && f2.imem_req;
      r2_rdata  <= f2.imem_addr;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      f.redirect_valid = 1'b0;
      f.redirect_pc    = '0;
      f.id_ready       = 1'b1;
      // 1: reset values and zero-wait streaming
      do_reset();
      check("rst_valid", f.id_valid, 0);
      check("rst_instr", f.id_instr, 32'h13);
      check("rst_pc", f.id_pc, 0);
      check("rst_req", f.imem_req, 0);
      check("rst_fault", f.fetch_fault, 0);
      tick();
      check("t1_req_c1", f.imem_req, 1);
      check("t1_addr_c1", f.imem_addr, 0);
      tick();
      check("t1_valid_c2", f.id_valid, 0);
      tick();
      check("t1_valid_c3", f.id_valid, 1);
      check("t1_pc_c3", f.id_pc, 0);
      check("t1_instr_c3", f.id_instr, 0);
      tick();
      check("t1_valid_c4", f.id_valid, 0);
      check("t1_nop_c4", f.id_instr, 32'h13);
      tick();
      check("t1_pc_c5", f.id_pc, 4);
      check("t1_instr_c5", f.id_instr, 4);
      tick(2);
      check("t1_pc_c7", f.id_pc, 8);
      check("t1_instr_c7", f.id_instr, 8);
      // 2: decode stall fills the skid buffer, release delivers in order
      f.id_ready = 1'b0;
      do_reset();
      xfers.delete();
      tick(3);
      check("t2_valid_c3", f.id_valid, 1);
      tick(2);
      for (int i = 0; i < 4; i++) begin
         check("t2_hold_req", f.imem_req, 0);
         check("t2_hold_valid", f.id_valid, 1);
         check("t2_hold_pc", f.id_pc, 0);
         check("t2_hold_instr", f.id_instr, 0);
         tick();
      end
      f.id_ready = 1'b1;
      tick();
      check("t2_pc_skid", f.id_pc, 4);
      check("t2_instr_skid", f.id_instr, 4);
      tick(3);
      check("t2_n_xfers", xfers.size(), 3);
      for (int i = 0; i < 3; i++)
         check("t2_xfer_pc", (i < xfers.size()) ? xfers[i] : 32'hDEAD_BEEF, exp_xfer[i]);
      // 3: grant delayed three cycles, response two cycles after grant
      gnt_wait = 3;
      rv_lat   = 2;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_req_held", f.imem_req, 1);
         check("t3_addr_held", f.imem_addr, 0);
      end
      tick();
      check("t3_req_wait", f.imem_req, 0);
      check("t3_valid_c5", f.id_valid, 0);
      tick();
      check("t3_valid_c6", f.id_valid, 0);
      tick();
      check("t3_valid_c7", f.id_valid, 1);
      check("t3_pc_c7", f.id_pc, 0);
      gnt_wait = 0;
      rv_lat   = 1;
      // 4: redirect while a granted response is outstanding
      f.id_ready = 1'b0;
      do_reset();
      tick(3);
      rv_lat = 3;
      tick();
      check("t4_valid_pre", f.id_valid, 1);
      f.redirect_valid = 1'b1;
      f.redirect_pc    = 32'h100;
      tick();
      f.redirect_valid = 1'b0;
      rv_lat           = 1;
      check("t4_flush_valid", f.id_valid, 0);
      check("t4_flush_instr", f.id_instr, 32'h13);
      check("t4_flush_req", f.imem_req, 0);
      tick();
      check("t4_drop_valid", f.id_valid, 0);
      check("t4_drop_instr", f.id_instr, 32'h13);
      tick();
      check("t4_req", f.imem_req, 1);
      check("t4_addr", f.imem_addr, 32'h100);
      tick(2);
      check("t4_valid", f.id_valid, 1);
      check("t4_pc", f.id_pc, 32'h100);
      check("t4_instr", f.id_instr, 32'h100);
      // 5: redirect coincident with rvalid, then misaligned redirect and recovery
      f.id_ready = 1'b1;
      do_reset();
      tick(2);
      f.redirect_valid = 1'b1;
      f.redirect_pc    = 32'h40;
      tick();
      f.redirect_valid = 1'b0;
      check("t5_coin_valid", f.id_valid, 0);
      check("t5_coin_req", f.imem_req, 0);
      tick();
      check("t5_coin_addr", f.imem_addr, 32'h40);
      check("t5_coin_reqhi", f.imem_req, 1);
      tick(2);
      check("t5_coin_pc", f.id_pc, 32'h40);
      check("t5_coin_vld", f.id_valid, 1);
      f.redirect_valid = 1'b1;
      f.redirect_pc    = 32'h102;
      tick();
      f.redirect_valid = 1'b0;
      check("t5_fault_set", f.fetch_fault, 1);
      check("t5_fault_req", f.imem_req, 0);
      check("t5_fault_valid", f.id_valid, 0);
      tick(2);
      check("t5_fault_hold", f.fetch_fault, 1);
      check("t5_fault_req2", f.imem_req, 0);
      f.redirect_valid = 1'b1;
      f.redirect_pc    = 32'h200;
      tick();
      f.redirect_valid = 1'b0;
      check("t5_fault_clr", f.fetch_fault, 0);
      tick();
      check("t5_resume_req", f.imem_req, 1);
      check("t5_resume_addr", f.imem_addr, 32'h200);
      tick(2);
      check("t5_resume_pc", f.id_pc, 32'h200);
      check("t5_resume_instr", f.id_instr, 32'h200);
      // 6: PC wraps modulo 2^32, then reset in the middle of a WAIT
      do_reset();
      tick(3);
      check("t6_wrap_pc0", f2.id_pc, 32'hFFFF_FFF8);
      check("t6_wrap_instr0", f2.id_instr, 32'hFFFF_FFF8);
      tick(2);
      check("t6_wrap_pc1", f2.id_pc, 32'hFFFF_FFFC);
      tick(2);
      check("t6_wrap_pc2", f2.id_pc, 32'h0);
      check("t6_wrap_valid2", f2.id_valid, 1);
      f.id_ready = 1'b0;
      do_reset();
      tick(3);
      rv_lat = 3;
      tick();
      check("t6_pre_valid", f.id_valid, 1);
      reset = 1'b1;
      tick();
      check("t6_rst_valid", f.id_valid, 0);
      check("t6_rst_instr", f.id_instr, 32'h13);
      check("t6_rst_pc", f.id_pc, 0);
      check("t6_rst_req", f.imem_req, 0);
      check("t6_rst_fault", f.fetch_fault, 0);
      reset      = 1'b0;
      rv_lat     = 1;
      f.id_ready = 1'b1;
      tick(3);
      check("t6_after_valid", f.id_valid, 1);
      check("t6_after_pc", f.id_pc, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
